// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch unit's pipeline-facing and ROM-facing signals.
//   interlock    : downstream stall, holds the output bundle
//   redirect     : branch/jump redirect strobe
//   redirect_pc  : new fetch byte address (aligned to 4*ISSUE_WIDTH)
//   imem_addr    : byte address presented to the instruction ROM
//   imem_rdata   : ROM data bundle, ROM_LATENCY cycles after imem_addr
//   inst_out     : instruction bundle to decode, slot 0 in the low bits
//   pc_out       : address of slot 0 of inst_out
//   valid_out    : inst_out holds fetched instructions rather than a bubble
// Modport slave is the fetch unit itself; master is the surrounding pipeline/ROM.
interface fetch_unit_if #(
    parameter int ISSUE_WIDTH = 2
) ();
    logic                      interlock;
    logic                      redirect;
    logic [31:0]               redirect_pc;
    logic [31:0]               imem_addr;
    logic [32*ISSUE_WIDTH-1:0] imem_rdata;
    logic [32*ISSUE_WIDTH-1:0] inst_out;
    logic [31:0]               pc_out;
    logic                      valid_out;

    modport master (
        output interlock, redirect, redirect_pc, imem_rdata,
        input  imem_addr, inst_out, pc_out, valid_out
    );

    modport slave (
        input  interlock, redirect, redirect_pc, imem_rdata,
        output imem_addr, inst_out, pc_out, valid_out
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: issues bundle-wide fetches to a fixed-latency instruction ROM,
// tracks outstanding requests with an epoch tag, buffers returning data in a
// skid FIFO sized so it never overflows, and presents one bundle per cycle.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fetch_unit_if.slave (interlock, redirect, redirect_pc, imem_addr,
//          imem_rdata, inst_out, pc_out, valid_out)
//   perf_bundles / perf_stalls : 32-bit wrapping counters, present only when
//          the macro FETCH_PERF_CNT_EN is defined
module fetch_unit #(
    parameter int          ISSUE_WIDTH = 2,
    parameter int          ROM_LATENCY = 1,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_bundles,
    output logic [31:0] perf_stalls,
`endif
    fetch_unit_if.slave bus
);
    localparam int DATA_W = 32 * ISSUE_WIDTH;
    localparam int DEPTH  = ROM_LATENCY + 1;
    localparam int PTR_W  = $clog2(DEPTH);
    // One spare bit so occupancy + in-flight can be summed without overflow.
    localparam int CNT_W  = $clog2(DEPTH + 1) + 1;
    localparam logic [31:0]       PC_STEP = 32'(4 * ISSUE_WIDTH);
    localparam logic [DATA_W-1:0] BUBBLE  = {ISSUE_WIDTH{32'hE000_0000}};

    logic [31:0]       pc_r;
    logic              epoch_r;
    logic              trk_valid_r [ROM_LATENCY];
    logic              trk_epoch_r [ROM_LATENCY];
    logic [31:0]       trk_pc_r    [ROM_LATENCY];
    logic [DATA_W-1:0] fifo_data_r [DEPTH];
    logic [31:0]       fifo_pc_r   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] inst_r;
    logic [31:0]       pc_out_r;
    logic              valid_r;

    logic [CNT_W-1:0]  inflight_s;
    logic [31:0]       req_pc_s;
    logic              issue_s;
    logic              ret_s;
    logic              pop_s;
    logic              bypass_s;
    logic              wr_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    // Count requests still expected back under the current epoch.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            if (trk_valid_r[i] && (trk_epoch_r[i] == epoch_r)) begin
                inflight_s = inflight_s + CNT_W'(1);
            end else begin
                inflight_s = inflight_s;
            end
        end
    end

    // Issue, return, pop and bypass decisions; redirect overrides everything.
    // An empty FIFO with no stall lets returning data go straight to the
    // output register, which gives ROM_LATENCY+1 fetch-to-output latency.
    always_comb begin
        req_pc_s = bus.redirect ? bus.redirect_pc : pc_r;
        issue_s  = bus.redirect || ((count_r + inflight_s) < CNT_W'(DEPTH));
        ret_s    = trk_valid_r[ROM_LATENCY-1] &&
                   (trk_epoch_r[ROM_LATENCY-1] == epoch_r) && !bus.redirect;
        pop_s    = !bus.redirect && !bus.interlock && (count_r != '0);
        bypass_s = !bus.redirect && !bus.interlock && (count_r == '0) && ret_s;
        wr_s     = ret_s && !bypass_s;
    end

    assign bus.imem_addr = req_pc_s;
    assign bus.inst_out  = inst_r;
    assign bus.pc_out    = pc_out_r;
    assign bus.valid_out = valid_r;

    // Fetch pc advances past each issued request; redirect flips the epoch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r    <= RESET_PC;
            epoch_r <= 1'b0;
        end else begin
            if (issue_s) begin
                pc_r <= req_pc_s + PC_STEP;
            end
            if (bus.redirect) begin
                epoch_r <= ~epoch_r;
            end
        end
    end

    // In-flight shift of {valid, epoch, pc}. Older entries are also killed on
    // redirect so back-to-back redirects cannot alias through the 1-bit epoch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                trk_valid_r[i] <= 1'b0;
                trk_epoch_r[i] <= 1'b0;
                trk_pc_r[i]    <= 32'h0000_0000;
            end
        end else begin
            trk_valid_r[0] <= issue_s;
            trk_epoch_r[0] <= bus.redirect ? ~epoch_r : epoch_r;
            trk_pc_r[0]    <= req_pc_s;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                trk_valid_r[i] <= trk_valid_r[i-1] && !bus.redirect;
                trk_epoch_r[i] <= trk_epoch_r[i-1];
                trk_pc_r[i]    <= trk_pc_r[i-1];
            end
        end
    end

    // Skid FIFO pointers and occupancy; redirect flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (bus.redirect) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_r + CNT_W'(wr_s) - CNT_W'(pop_s);
        end
    end

    // Skid FIFO storage; contents are qualified by count_r so need no reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            fifo_data_r[wr_ptr_r] <= bus.imem_rdata;
            fifo_pc_r[wr_ptr_r]   <= trk_pc_r[ROM_LATENCY-1];
        end
    end

    // Output register: redirect bubble, else pop/bypass, else bubble, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_r   <= BUBBLE;
            pc_out_r <= 32'h0000_0000;
            valid_r  <= 1'b0;
        end else if (bus.redirect) begin
            inst_r   <= BUBBLE;
            pc_out_r <= 32'h0000_0000;
            valid_r  <= 1'b0;
        end else if (pop_s) begin
            inst_r   <= fifo_data_r[rd_ptr_r];
            pc_out_r <= fifo_pc_r[rd_ptr_r];
            valid_r  <= 1'b1;
        end else if (bypass_s) begin
            inst_r   <= bus.imem_rdata;
            pc_out_r <= trk_pc_r[ROM_LATENCY-1];
            valid_r  <= 1'b1;
        end else if (!bus.interlock) begin
            inst_r   <= BUBBLE;
            pc_out_r <= 32'h0000_0000;
            valid_r  <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Delivered-bundle and stall-cycle counters, free-running and wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bundles <= 32'h0000_0000;
            perf_stalls  <= 32'h0000_0000;
        end else begin
            if (valid_r && !bus.interlock) begin
                perf_bundles <= perf_bundles + 32'h0000_0001;
            end
            if (bus.interlock) begin
                perf_stalls <= perf_stalls + 32'h0000_0001;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: two fetch units (ROM latency 1 and 3) share the same
// interlock/redirect stimulus. Each ROM returns word = byte address per slot.
// Expected pc streams are queued at each (re)start and popped by a monitor
// whenever a DUT delivers a bundle (valid_out=1 with interlock=0).
module tb_fetch_unit;
    localparam int          IW  = 2;
    localparam logic [31:0] BUB = 32'hE000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        interlock = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int compared = 0;
    int mismatched = 0;
    int cons_a = 0;
    int cons_b = 0;
    logic [31:0] q_a [$];
    logic [31:0] q_b [$];
    logic [31:0] exp_a;
    logic [31:0] exp_b;

    always #5 clk = ~clk;

    fetch_unit_if #(.ISSUE_WIDTH(IW)) bus_a ();
    fetch_unit_if #(.ISSUE_WIDTH(IW)) bus_b ();

    assign bus_a.interlock   = interlock;
    assign bus_a.redirect    = redirect;
    assign bus_a.redirect_pc = redirect_pc;
    assign bus_b.interlock   = interlock;
    assign bus_b.redirect    = redirect;
    assign bus_b.redirect_pc = redirect_pc;

    // ROM models: latency 1 for instance a, latency 3 for instance b.
    logic [31:0] a_d1;
    logic [31:0] b_d1;
    logic [31:0] b_d2;
    logic [31:0] b_d3;
    always @(posedge clk) begin
        a_d1 <= bus_a.imem_addr;
        b_d1 <= bus_b.imem_addr;
        b_d2 <= b_d1;
        b_d3 <= b_d2;
    end
    assign bus_a.imem_rdata = {a_d1 + 32'd4, a_d1};
    assign bus_b.imem_rdata = {b_d3 + 32'd4, b_d3};

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_bundles_a;
    logic [31:0] perf_stalls_a;
    logic [31:0] perf_bundles_b;
    logic [31:0] perf_stalls_b;
    int exp_bundles = 0;
    int exp_stalls = 0;
`endif

    fetch_unit #(.ISSUE_WIDTH(IW), .ROM_LATENCY(1), .RESET_PC(32'h0)) dut_a (
        .clk          (clk),
        .rst          (rst),
`ifdef FETCH_PERF_CNT_EN
        .perf_bundles (perf_bundles_a),
        .perf_stalls  (perf_stalls_a),
`endif
        .bus          (bus_a)
    );

    fetch_unit #(.ISSUE_WIDTH(IW), .ROM_LATENCY(3), .RESET_PC(32'h0)) dut_b (
        .clk          (clk),
        .rst          (rst),
`ifdef FETCH_PERF_CNT_EN
        .perf_bundles (perf_bundles_b),
        .perf_stalls  (perf_stalls_b),
`endif
        .bus          (bus_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_stream(input logic [31:0] start);
        q_a.delete();
        q_b.delete();
        for (int i = 0; i < 64; i++) begin
            q_a.push_back(start + 32'(8 * i));
            q_b.push_back(start + 32'(8 * i));
        end
    endtask

    // Scoreboard monitor, instance a.
    always @(negedge clk) begin
        if (!rst && bus_a.valid_out && !interlock) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_bundle", {32'h0, bus_a.pc_out}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_a = q_a.pop_front();
                check("a_pc", {32'h0, bus_a.pc_out}, {32'h0, exp_a});
                check("a_inst", bus_a.inst_out, {exp_a + 32'd4, exp_a});
                cons_a++;
            end
        end
    end

    // Scoreboard monitor, instance b.
    always @(negedge clk) begin
        if (!rst && bus_b.valid_out && !interlock) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_bundle", {32'h0, bus_b.pc_out}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_b = q_b.pop_front();
                check("b_pc", {32'h0, bus_b.pc_out}, {32'h0, exp_b});
                check("b_inst", bus_b.inst_out, {exp_b + 32'd4, exp_b});
                cons_b++;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Expected counter contributions for the coming rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.valid_out && !interlock) exp_bundles++;
            if (interlock) exp_stalls++;
        end
    end
`endif

    // Called just after a rising edge; returns just after the redirect edge.
    task automatic do_redirect(input logic [31:0] pc, input logic hold);
        redirect    = 1'b1;
        redirect_pc = pc;
        interlock   = hold;
        @(negedge clk);
        check("a_addr_on_redirect", {32'h0, bus_a.imem_addr}, {32'h0, pc});
        check("b_addr_on_redirect", {32'h0, bus_b.imem_addr}, {32'h0, pc});
        @(posedge clk);
        #1;
        redirect = 1'b0;
        load_stream(pc);
    endtask

    // Bubble right after redirect, next address, and cycles to first valid.
    task automatic measure(input logic [31:0] pc, input int il_cycles,
                           input int want_a, input int want_b);
        int fa;
        int fb;
        fa = 0;
        fb = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("a_next_addr", {32'h0, bus_a.imem_addr}, {32'h0, pc + 32'd8});
                check("b_next_addr", {32'h0, bus_b.imem_addr}, {32'h0, pc + 32'd8});
                check("a_bubble_valid", {63'h0, bus_a.valid_out}, 64'h0);
                check("b_bubble_valid", {63'h0, bus_b.valid_out}, 64'h0);
                check("a_bubble_inst", bus_a.inst_out, {BUB, BUB});
                check("b_bubble_inst", bus_b.inst_out, {BUB, BUB});
            end
            if (fa == 0 && bus_a.valid_out) fa = i;
            if (fb == 0 && bus_b.valid_out) fb = i;
            if (i == il_cycles) begin
                @(posedge clk);
                #1;
                interlock = 1'b0;
            end
        end
        check("a_redirect_latency", 64'(fa), 64'(want_a));
        check("b_redirect_latency", 64'(fb), 64'(want_b));
    endtask

    initial begin
        int fa;
        int fb;
        load_stream(32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("a_rst_addr", {32'h0, bus_a.imem_addr}, 64'h0);
        check("a_rst_valid", {63'h0, bus_a.valid_out}, 64'h0);
        check("a_rst_pc", {32'h0, bus_a.pc_out}, 64'h0);
        check("a_rst_inst", bus_a.inst_out, {BUB, BUB});
        check("b_rst_valid", {63'h0, bus_b.valid_out}, 64'h0);
        check("b_rst_inst", bus_b.inst_out, {BUB, BUB});
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cycle 0 is the first cycle after release; first issue at its end.
        fa = -1;
        fb = -1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (fa < 0 && bus_a.valid_out) fa = c;
            if (fb < 0 && bus_b.valid_out) fb = c;
        end
        check("a_first_valid_cycle", 64'(fa), 64'd2);
        check("b_first_valid_cycle", 64'(fb), 64'd4);

        // Interlock for cycles 6..10.
        @(posedge clk);
        @(posedge clk);
        #1;
        interlock = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("a_stall_addr", {32'h0, bus_a.imem_addr}, 64'h38);
        check("a_stall_pc", {32'h0, bus_a.pc_out}, 64'h20);
        check("a_stall_valid", {63'h0, bus_a.valid_out}, 64'h1);
        check("b_stall_addr", {32'h0, bus_b.imem_addr}, 64'h38);
        check("b_stall_pc", {32'h0, bus_b.pc_out}, 64'h10);
        check("b_stall_valid", {63'h0, bus_b.valid_out}, 64'h1);
        @(posedge clk);
        #1;
        interlock = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        do_redirect(32'h0000_0100, 1'b0);
        measure(32'h0000_0100, 0, 2, 4);
        @(posedge clk);
        #1;
        do_redirect(32'hFFFF_FFF8, 1'b0);
        measure(32'hFFFF_FFF8, 0, 2, 4);
        @(posedge clk);
        #1;
        do_redirect(32'h0000_0200, 1'b1);
        measure(32'h0000_0200, 2, 4, 4);

        repeat (10) @(posedge clk);
        #1;
        check("a_bundles_delivered_ge_20", {63'h0, cons_a >= 20}, 64'h1);
        check("b_bundles_delivered_ge_20", {63'h0, cons_b >= 20}, 64'h1);
`ifdef FETCH_PERF_CNT_EN
        check("a_perf_bundles", {32'h0, perf_bundles_a}, 64'(exp_bundles));
        check("a_perf_stalls", {32'h0, perf_stalls_a}, 64'(exp_stalls));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
